// File: rtl/reg_ctx_engine.sv
// Register-file context engine: block-saves all NREGS registers to data memory
// or restores them from memory, one register slot per clock, gated by a mask.
module reg_ctx_engine #(
  parameter int NREGS = 16,
  parameter int RAW   = 4,
  parameter int DW    = 8,
  parameter int MAW   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [MAW-1:0]   base_addr,
  input  logic [NREGS-1:0] reg_mask,
  output logic             busy,
  output logic             done,
  output logic             RegWrite,
  output logic [RAW-1:0]   write_register,
  output logic [DW-1:0]    data_in,
  output logic [RAW-1:0]   raddrA,
  input  logic [DW-1:0]    data_outA,
  output logic [MAW-1:0]   mem_addr,
  output logic             mem_wr_en,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata
);

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;

  state_t           state_q, state_d;
  logic [RAW-1:0]   idx_q, idx_d;
  logic             mode_q, mode_d;
  logic [MAW-1:0]   base_q, base_d;
  logic [NREGS-1:0] mask_q, mask_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    base_d  = base_q;
    mask_d  = mask_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          base_d  = base_addr;
          mask_d  = reg_mask;
          idx_d   = '0;
          state_d = mode ? RESTORE : SAVE;
        end
      end
      SAVE, RESTORE: begin
        idx_d = idx_q + RAW'(1);
        if (idx_q == RAW'(NREGS - 1)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // busy/done are registered off the next state so they align with it
    busy_d = (state_d == SAVE) || (state_d == RESTORE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      base_q  <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  // Datapath outputs are forced to zero outside the active transfer states.
  always_comb begin
    RegWrite       = 1'b0;
    write_register = '0;
    data_in        = '0;
    raddrA         = '0;
    mem_addr       = '0;
    mem_wr_en      = 1'b0;
    mem_wdata      = '0;
    if (state_q == SAVE) begin
      raddrA    = idx_q;
      mem_addr  = base_q + MAW'(idx_q);
      mem_wdata = data_outA;
      mem_wr_en = mask_q[idx_q];
    end else if (state_q == RESTORE) begin
      mem_addr       = base_q + MAW'(idx_q);
      write_register = idx_q;
      data_in        = mem_rdata;
      RegWrite       = mask_q[idx_q];
    end
  end

endmodule

// File: tb/tb_reg_ctx_engine.sv
// Directed bench for reg_ctx_engine with behavioural reg_file and data memory.
module tb_reg_ctx_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [7:0]  base_addr;
  logic [15:0] reg_mask;
  logic        busy;
  logic        done;
  logic        RegWrite;
  logic [3:0]  write_register;
  logic [7:0]  data_in;
  logic [3:0]  raddrA;
  logic [7:0]  data_outA;
  logic [7:0]  mem_addr;
  logic        mem_wr_en;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  rf  [16];
  logic [7:0]  mem [256];
  logic        tb_rf_we;
  logic [3:0]  tb_rf_addr;
  logic [7:0]  tb_rf_data;
  logic        tb_mem_we;
  logic [7:0]  tb_mem_addr;
  logic [7:0]  tb_mem_data;

  int n_checks;
  int n_fail;
  int tcnt;
  int done_at;
  int wr_cnt;
  int rw_cnt;
  int done_cnt;
  int both_hi;
  logic [7:0] addr_log[$];
  logic [7:0] exp_q[$];

  reg_ctx_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .base_addr(base_addr), .reg_mask(reg_mask), .busy(busy), .done(done),
    .RegWrite(RegWrite), .write_register(write_register), .data_in(data_in),
    .raddrA(raddrA), .data_outA(data_outA), .mem_addr(mem_addr),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // clock / models
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data_outA = rf[raddrA];
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    else if (tb_mem_we) mem[tb_mem_addr] <= tb_mem_data;
    if (RegWrite) rf[write_register] <= data_in;
    else if (tb_rf_we) rf[tb_rf_addr] <= tb_rf_data;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  // driver tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tcnt++;
    if (mem_wr_en) begin
      wr_cnt++;
      addr_log.push_back(mem_addr);
    end
    if (RegWrite) rw_cnt++;
    if (done) begin
      done_cnt++;
      if (done_at == 0) done_at = tcnt;
    end
    if (busy && done) both_hi++;
  endtask

  task automatic rf_load(input logic [3:0] a, input logic [7:0] d);
    tb_rf_we = 1'b1; tb_rf_addr = a; tb_rf_data = d;
    tick();
    tb_rf_we = 1'b0;
  endtask

  task automatic mem_load(input logic [7:0] a, input logic [7:0] d);
    tb_mem_we = 1'b1; tb_mem_addr = a; tb_mem_data = d;
    tick();
    tb_mem_we = 1'b0;
  endtask

  task automatic start_xfer(input logic m, input logic [7:0] b, input logic [15:0] k);
    tcnt = 0; done_at = 0; wr_cnt = 0; rw_cnt = 0; done_cnt = 0;
    addr_log.delete();
    mode = m; base_addr = b; reg_mask = k; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 40 && done_at == 0; i++) tick();
    check(tag, 32'(done_at), 32'd17);
  endtask

  // directed sequence
  initial begin
    int hit60;
    int d2;
    logic b18, b19;
    logic [7:0] a19;
    n_checks = 0; n_fail = 0; both_hi = 0;
    tcnt = 0; done_at = 0; wr_cnt = 0; rw_cnt = 0; done_cnt = 0;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; base_addr = '0; reg_mask = '0;
    tb_rf_we = 1'b0; tb_rf_addr = '0; tb_rf_data = '0;
    tb_mem_we = 1'b0; tb_mem_addr = '0; tb_mem_data = '0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_regwrite", 32'(RegWrite), 0);
    check("rst_mem_wr_en", 32'(mem_wr_en), 0);
    check("rst_outputs_or", 32'({mem_addr, raddrA, write_register, data_in, mem_wdata}), 0);
    rst_n = 1'b1;
    tick();

    // save, full mask
    for (int i = 0; i < 16; i++) rf_load(4'(i), 8'(8'h10 + i));
    start_xfer(1'b0, 8'h40, 16'hFFFF);
    wait_done("save_done_latency");
    check("save_wr_cnt", 32'(wr_cnt), 16);
    check("save_regwrite_cnt", 32'(rw_cnt), 0);
    tick();
    check("save_busy_after", 32'(busy), 0);
    check("save_idle_addr", 32'(mem_addr), 0);
    for (int i = 0; i < 16; i++) check("save_mem", 32'(mem[8'(8'h40 + i)]), 32'(8'h10 + i));

    // restore, partial mask
    for (int i = 0; i < 16; i++) rf_load(4'(i), 8'h00);
    for (int i = 0; i < 16; i++) mem_load(8'(8'h80 + i), 8'(8'hA0 + i));
    start_xfer(1'b1, 8'h80, 16'h00F1);
    wait_done("restore_done_latency");
    check("restore_regwrite_cnt", 32'(rw_cnt), 5);
    check("restore_mem_wr_cnt", 32'(wr_cnt), 0);
    check("restore_r0", 32'(rf[0]), 32'h A0);
    check("restore_r1", 32'(rf[1]), 0);
    check("restore_r3", 32'(rf[3]), 0);
    check("restore_r4", 32'(rf[4]), 32'hA4);
    check("restore_r5", 32'(rf[5]), 32'hA5);
    check("restore_r6", 32'(rf[6]), 32'hA6);
    check("restore_r7", 32'(rf[7]), 32'hA7);
    check("restore_r8", 32'(rf[8]), 0);
    check("restore_r15", 32'(rf[15]), 0);

    // wrap-around save
    for (int i = 0; i < 16; i++) rf_load(4'(i), 8'(8'h30 + i));
    start_xfer(1'b0, 8'hF8, 16'hFFFF);
    wait_done("wrap_done_latency");
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'hF8 + i));
    check("wrap_log_len", 32'(addr_log.size()), 16);
    while (exp_q.size() > 0 && addr_log.size() > 0)
      check("wrap_addr_seq", 32'(addr_log.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    check("wrap_mem00_r8", 32'(mem[0]), 32'h38);
    check("wrap_memFF_r7", 32'(mem[255]), 32'h37);
    tick();

    // start held during transfer
    hit60 = 0; d2 = 0; b18 = 1'b1; b19 = 1'b0; a19 = '0;
    start_xfer(1'b0, 8'h00, 16'hFFFF);
    tick();
    start = 1'b1; base_addr = 8'h60;
    while (tcnt < 40) begin
      tick();
      if (tcnt == 20) start = 1'b0;
      if (tcnt <= 17 && mem_wr_en && mem_addr[7:4] == 4'h6) hit60++;
      if (tcnt == 18) b18 = busy;
      if (tcnt == 19) begin b19 = busy; a19 = mem_addr; end
      if (tcnt == 20) check("held_done_cnt_first", 32'(done_cnt), 1);
      if (done && tcnt > 17 && d2 == 0) d2 = tcnt;
    end
    check("held_first_done", 32'(done_at), 17);
    check("held_no_60_writes", 32'(hit60), 0);
    check("held_busy_c18", 32'(b18), 0);
    check("held_busy_c19", 32'(b19), 1);
    check("held_addr_c19", 32'(a19), 32'h60);
    check("held_second_done", 32'(d2), 35);
    check("held_mem6A", 32'(mem[8'h6A]), 32'h3A);
    check("held_mem05", 32'(mem[8'h05]), 32'h35);

    // reset mid-restore
    for (int i = 0; i < 16; i++) rf_load(4'(i), 8'(8'h50 + i));
    start_xfer(1'b1, 8'h80, 16'hFFFF);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstmid_regwrite", 32'(RegWrite), 0);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_mem_addr", 32'(mem_addr), 0);
    repeat (20) tick();
    check("rstmid_no_done", 32'(done_cnt), 0);
    check("rstmid_rw_cnt", 32'(rw_cnt), 6);
    for (int i = 0; i < 6; i++) check("rstmid_restored", 32'(rf[i]), 32'(8'hA0 + i));
    for (int i = 6; i < 16; i++) check("rstmid_unchanged", 32'(rf[i]), 32'(8'h50 + i));

    // empty mask
    start_xfer(1'b0, 8'hC0, 16'h0000);
    wait_done("empty_done_latency");
    check("empty_wr_cnt", 32'(wr_cnt), 0);
    check("empty_done_cnt", 32'(done_cnt), 1);
    tick();
    check("empty_busy_after", 32'(busy), 0);

    check("busy_done_overlap", 32'(both_hi), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
